// File: rtl/ucie_ctl_sb_rx_packet_receiver.sv
// Sideband RX packet receiver: deserializes RDI config beats into 32-bit phases,
// reassembles 2- or 4-phase sideband messages and hands them to CTL with one-packet credit flow.
module ucie_ctl_sb_rx_packet_receiver #(
  parameter int NC = 32
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_rdi_pl_cfg_vld,
  input  logic [NC-1:0] i_rdi_pl_cfg,
  output logic          o_rdi_lp_cfg_crd,
  output logic          o_valid_pl_sb,
  output logic [4:0]    o_pl_sb_decode,
  output logic          o_pl_sb_has_data,
  output logic [31:0]   o_pl_sb_data,
  input  logic          i_pl_sb_ack,
  output logic          o_sb_overflow
);

  localparam int BPP = 32 / NC;
  localparam int BW  = (BPP > 1) ? $clog2(BPP) : 1;
  localparam logic [4:0] OPC_DATA = 5'b11011;

  typedef enum logic [1:0] {
    ST_INIT    = 2'd0,
    ST_IDLE    = 2'd1,
    ST_COLLECT = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  state_t        state_r;
  state_t        state_next_s;
  logic [BW-1:0] beat_cnt_r;
  logic [BW-1:0] beat_idx_s;
  logic [1:0]    phase_cnt_r;
  logic [1:0]    phase_idx_s;
  logic [31:0]   phase_buf_r;
  logic [31:0]   phase_word_s;
  logic [31:0]   data_cap_r;
  logic [4:0]    decode_cap_r;
  logic          four_phase_r;
  logic          accept_s;
  logic          last_beat_s;
  logic          last_phase_s;
  logic          pkt_done_s;
  logic          crd_next_s;
  logic          valid_next_s;

  // Beat position, phase completion and the phase word as it looks with the current beat merged in.
  // In IDLE the counters are treated as zero so the first beat always lands at beat 0 of phase 0.
  always_comb begin
    accept_s = i_rdi_pl_cfg_vld && ((state_r == ST_IDLE) || (state_r == ST_COLLECT));
    if (state_r == ST_COLLECT) begin
      beat_idx_s  = beat_cnt_r;
      phase_idx_s = phase_cnt_r;
    end else begin
      beat_idx_s  = '0;
      phase_idx_s = 2'd0;
    end
    last_beat_s = (beat_idx_s == BW'(BPP - 1));
    if (phase_idx_s == 2'd3) begin
      last_phase_s = 1'b1;
    end else if (phase_idx_s == 2'd1) begin
      last_phase_s = !four_phase_r;
    end else begin
      last_phase_s = 1'b0;
    end
    pkt_done_s   = accept_s && last_beat_s && last_phase_s;
    phase_word_s = phase_buf_r;
    for (int k = 0; k < BPP; k++) begin
      if (beat_idx_s == BW'(k)) begin
        phase_word_s[k*NC +: NC] = i_rdi_pl_cfg;
      end else begin
        phase_word_s[k*NC +: NC] = phase_buf_r[k*NC +: NC];
      end
    end
  end

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= ST_INIT;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_INIT:    state_next_s = ST_IDLE;
      ST_IDLE:    state_next_s = accept_s ? ST_COLLECT : ST_IDLE;
      ST_COLLECT: state_next_s = pkt_done_s ? ST_HOLD : ST_COLLECT;
      ST_HOLD:    state_next_s = i_pl_sb_ack ? ST_IDLE : ST_HOLD;
      default:    state_next_s = ST_INIT;
    endcase
  end

  // Output decode; the credit goes back once at start-up and once per consumed message.
  always_comb begin
    crd_next_s   = (state_r == ST_INIT) || ((state_r == ST_HOLD) && i_pl_sb_ack);
    valid_next_s = (state_next_s == ST_HOLD);
  end

  // Beat/phase counters and per-phase capture; phase3 is counted but never stored.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      beat_cnt_r   <= '0;
      phase_cnt_r  <= 2'd0;
      phase_buf_r  <= 32'd0;
      data_cap_r   <= 32'd0;
      decode_cap_r <= 5'd0;
      four_phase_r <= 1'b0;
    end else if (accept_s) begin
      phase_buf_r <= phase_word_s;
      if (last_beat_s) begin
        beat_cnt_r  <= '0;
        phase_cnt_r <= pkt_done_s ? 2'd0 : (phase_idx_s + 2'd1);
        case (phase_idx_s)
          2'd0:    four_phase_r <= (phase_word_s[4:0] == OPC_DATA);
          2'd1:    decode_cap_r <= phase_word_s[4:0];
          2'd2:    data_cap_r   <= phase_word_s;
          default: data_cap_r   <= data_cap_r;
        endcase
      end else begin
        beat_cnt_r  <= beat_idx_s + BW'(1);
        phase_cnt_r <= phase_idx_s;
      end
    end
  end

  // Registered outputs; message fields load only when the packet completes.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_rdi_lp_cfg_crd <= 1'b0;
      o_valid_pl_sb    <= 1'b0;
      o_pl_sb_decode   <= 5'd0;
      o_pl_sb_has_data <= 1'b0;
      o_pl_sb_data     <= 32'd0;
      o_sb_overflow    <= 1'b0;
    end else begin
      o_rdi_lp_cfg_crd <= crd_next_s;
      o_valid_pl_sb    <= valid_next_s;
      if (i_rdi_pl_cfg_vld && (state_r == ST_HOLD)) begin
        o_sb_overflow <= 1'b1;
      end
      if (pkt_done_s) begin
        o_pl_sb_decode   <= (phase_idx_s == 2'd1) ? phase_word_s[4:0] : decode_cap_r;
        o_pl_sb_has_data <= four_phase_r;
        o_pl_sb_data     <= four_phase_r ? data_cap_r : 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_ucie_ctl_sb_rx_packet_receiver.sv
// Directed bench for the sideband RX packet receiver: three instances (NC=8/16/32)
// driven from a vector table plus hand-written reset, hold, overflow and mid-packet-reset sequences.
module tb_ucie_ctl_sb_rx_packet_receiver;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] vld;
  logic [2:0] ack;
  logic [7:0]  cfg8;
  logic [15:0] cfg16;
  logic [31:0] cfg32;
  logic [2:0] crd, valid, hd, ovf;
  logic [2:0][4:0]  dec;
  logic [2:0][31:0] dat;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ucie_ctl_sb_rx_packet_receiver #(.NC(8)) u_nc8 (
    .i_clk(clk), .i_rst(rst), .i_rdi_pl_cfg_vld(vld[0]), .i_rdi_pl_cfg(cfg8),
    .o_rdi_lp_cfg_crd(crd[0]), .o_valid_pl_sb(valid[0]), .o_pl_sb_decode(dec[0]),
    .o_pl_sb_has_data(hd[0]), .o_pl_sb_data(dat[0]), .i_pl_sb_ack(ack[0]), .o_sb_overflow(ovf[0]));

  ucie_ctl_sb_rx_packet_receiver #(.NC(16)) u_nc16 (
    .i_clk(clk), .i_rst(rst), .i_rdi_pl_cfg_vld(vld[1]), .i_rdi_pl_cfg(cfg16),
    .o_rdi_lp_cfg_crd(crd[1]), .o_valid_pl_sb(valid[1]), .o_pl_sb_decode(dec[1]),
    .o_pl_sb_has_data(hd[1]), .o_pl_sb_data(dat[1]), .i_pl_sb_ack(ack[1]), .o_sb_overflow(ovf[1]));

  ucie_ctl_sb_rx_packet_receiver #(.NC(32)) u_nc32 (
    .i_clk(clk), .i_rst(rst), .i_rdi_pl_cfg_vld(vld[2]), .i_rdi_pl_cfg(cfg32),
    .o_rdi_lp_cfg_crd(crd[2]), .o_valid_pl_sb(valid[2]), .o_pl_sb_decode(dec[2]),
    .o_pl_sb_has_data(hd[2]), .o_pl_sb_data(dat[2]), .i_pl_sb_ack(ack[2]), .o_sb_overflow(ovf[2]));

  typedef struct {
    int          inst;
    logic [31:0] p0;
    logic [31:0] p1;
    logic [31:0] p2;
    logic [31:0] p3;
    int          gap;
    logic [4:0]  exp_dec;
    logic        exp_hd;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int i, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s nc%0d: got 0x%08h expected 0x%08h", name, 8 << i, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int i, input logic [31:0] w);
    case (i)
      0:       cfg8  = w[7:0];
      1:       cfg16 = w[15:0];
      default: cfg32 = w;
    endcase
  endtask

  task automatic send_pkt(input int i, input logic [31:0] p0, input logic [31:0] p1,
                          input logic [31:0] p2, input logic [31:0] p3, input int gap);
    logic [31:0] ph[4];
    int nc;
    int bpp;
    int nph;
    ph[0] = p0; ph[1] = p1; ph[2] = p2; ph[3] = p3;
    nc  = 8 << i;
    bpp = 32 / nc;
    nph = (p0[4:0] == 5'b11011) ? 4 : 2;
    for (int p = 0; p < nph; p++) begin
      for (int k = 0; k < bpp; k++) begin
        if (!(p == 0 && k == 0)) repeat (gap) step();
        if (p == nph - 1 && k == bpp - 1) chk("valid_before_last_beat", i, 32'(valid[i]), 32'd0);
        drive(i, ph[p] >> (k * nc));
        vld[i] = 1'b1;
        step();
        vld[i] = 1'b0;
      end
    end
  endtask

  task automatic check_hold(input int i, input logic [4:0] d, input logic h, input logic [31:0] data);
    chk("valid", i, 32'(valid[i]), 32'd1);
    chk("decode", i, 32'(dec[i]), 32'(d));
    chk("has_data", i, 32'(hd[i]), 32'(h));
    chk("data", i, dat[i], data);
    chk("crd_in_hold", i, 32'(crd[i]), 32'd0);
  endtask

  task automatic do_ack(input int i);
    ack[i] = 1'b1;
    step();
    ack[i] = 1'b0;
    chk("valid_after_ack", i, 32'(valid[i]), 32'd0);
    chk("crd_after_ack", i, 32'(crd[i]), 32'd1);
    step();
    chk("crd_pulse_end", i, 32'(crd[i]), 32'd0);
  endtask

  task automatic check_zero(input int i);
    chk("rst_crd", i, 32'(crd[i]), 32'd0);
    chk("rst_valid", i, 32'(valid[i]), 32'd0);
    chk("rst_decode", i, 32'(dec[i]), 32'd0);
    chk("rst_has_data", i, 32'(hd[i]), 32'd0);
    chk("rst_data", i, dat[i], 32'd0);
    chk("rst_overflow", i, 32'(ovf[i]), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{0, 32'h0000_0012, 32'h0000_0005, 32'h0, 32'h0, 0, 5'h05, 1'b0, 32'h0};
    vecs[1] = '{1, 32'h0000_001B, 32'h0000_0009, 32'hDEAD_BEEF, 32'h1234_5678, 0, 5'h09, 1'b1, 32'hDEAD_BEEF};
    vecs[2] = '{2, 32'h0000_001B, 32'h0000_0009, 32'hDEAD_BEEF, 32'h1234_5678, 2, 5'h09, 1'b1, 32'hDEAD_BEEF};
    vecs[3] = '{0, 32'hABCD_E01B, 32'hFFFF_FFF3, 32'h0102_0304, 32'h5555_AAAA, 1, 5'h13, 1'b1, 32'h0102_0304};
    vecs[4] = '{1, 32'h0000_003A, 32'h0000_001F, 32'h0, 32'h0, 0, 5'h1F, 1'b0, 32'h0};
    vecs[5] = '{2, 32'h0000_001F, 32'h0000_0055, 32'h0, 32'h0, 0, 5'h15, 1'b0, 32'h0};
    vecs[6] = '{0, 32'h0000_003B, 32'h0000_0002, 32'hCAFE_F00D, 32'h0, 0, 5'h02, 1'b1, 32'hCAFE_F00D};

    rst = 1'b1; vld = 3'b000; ack = 3'b000;
    cfg8 = 8'h00; cfg16 = 16'h0000; cfg32 = 32'h0;
    repeat (3) step();
    for (int i = 0; i < 3; i++) check_zero(i);

    // Reset release: one credit pulse after the first edge, then silence.
    rst = 1'b0;
    for (int i = 0; i < 3; i++) chk("crd_before_first_edge", i, 32'(crd[i]), 32'd0);
    step();
    for (int i = 0; i < 3; i++) chk("init_crd_pulse", i, 32'(crd[i]), 32'd1);
    repeat (3) begin
      step();
      for (int i = 0; i < 3; i++) chk("crd_after_init", i, 32'(crd[i]), 32'd0);
    end

    for (int v = 0; v < 7; v++) begin
      send_pkt(vecs[v].inst, vecs[v].p0, vecs[v].p1, vecs[v].p2, vecs[v].p3, vecs[v].gap);
      check_hold(vecs[v].inst, vecs[v].exp_dec, vecs[v].exp_hd, vecs[v].exp_data);
      do_ack(vecs[v].inst);
    end

    // Ack while nothing is pending is ignored.
    ack[0] = 1'b1;
    step();
    ack[0] = 1'b0;
    chk("idle_ack_crd", 0, 32'(crd[0]), 32'd0);
    chk("idle_ack_valid", 0, 32'(valid[0]), 32'd0);

    // Held message with no ack, then an extra beat while holding.
    send_pkt(2, 32'h0000_001B, 32'h0000_0009, 32'hDEAD_BEEF, 32'h1234_5678, 3);
    repeat (5) begin
      step();
      check_hold(2, 5'h09, 1'b1, 32'hDEAD_BEEF);
    end
    chk("overflow_before", 2, 32'(ovf[2]), 32'd0);
    cfg32 = 32'h0000_00AA;
    vld[2] = 1'b1;
    step();
    vld[2] = 1'b0;
    chk("overflow_set", 2, 32'(ovf[2]), 32'd1);
    check_hold(2, 5'h09, 1'b1, 32'hDEAD_BEEF);
    do_ack(2);
    chk("overflow_sticky", 2, 32'(ovf[2]), 32'd1);
    send_pkt(2, 32'h0000_0012, 32'h0000_000B, 32'h0, 32'h0, 0);
    check_hold(2, 5'h0B, 1'b0, 32'h0);
    do_ack(2);

    // Reset three beats into a data packet on NC=8.
    for (int k = 0; k < 3; k++) begin
      drive(0, 32'h0000_001B >> (k * 8));
      vld[0] = 1'b1;
      step();
      vld[0] = 1'b0;
    end
    rst = 1'b1;
    step();
    check_zero(0);
    chk("overflow_cleared_by_rst", 2, 32'(ovf[2]), 32'd0);
    rst = 1'b0;
    step();
    chk("reinit_crd_pulse", 0, 32'(crd[0]), 32'd1);
    step();
    chk("reinit_crd_end", 0, 32'(crd[0]), 32'd0);
    send_pkt(0, 32'h0000_0012, 32'h0000_0007, 32'h0, 32'h0, 0);
    check_hold(0, 5'h07, 1'b0, 32'h0);
    do_ack(0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
